mult_share_arbiter: RTL
=======================

// Module: mult_share_arbiter
// PURPOSE
//  Shares one sequential multiplier (start/done handshake) between two requesters.
//  - Round-robin arbitration between requesters 0 and 1.
//  - Latches the granted requester's operands and pulses mul_start.
//  - Waits for a qualified mul_done, then returns the product with a one-cycle response pulse.
//  - Watchdog aborts a job if done never arrives.
// PARAMETERS
//  WIDTH    8   operand width; product is 2*WIDTH
//  TIMEOUT  64  max cycles in WAIT before abort (>=2); counter is $clog2(TIMEOUT+1) bits
// PORTS
//  clk          in   1        rising-edge clock
//  rst          in   1        asynchronous, active-high reset
//  req0, req1   in   1        request; sampled only in IDLE
//  x0, y0       in   WIDTH    requester 0 operands; valid in the cycle req0 is sampled
//  x1, y1       in   WIDTH    requester 1 operands
//  gnt0, gnt1   out  1        1-cycle pulse: request accepted, operands captured
//  rsp0, rsp1   out  1        1-cycle pulse: result0/result1 valid (or error)
//  err0, err1   out  1        1-cycle pulse with rspN: job aborted by watchdog
//  result0      out  2*WIDTH  last result for requester 0; held until overwritten
//  result1      out  2*WIDTH  last result for requester 1; held until overwritten
//  busy         out  1        high in every state except IDLE
//  mul_start    out  1        1-cycle start pulse to multiplier
//  mul_x, mul_y out  WIDTH    latched operands; stable from ISSUE until leaving WAIT
//  mul_done     in   1        multiplier done (level; may already be high when idle)
//  mul_product  in   2*WIDTH  multiplier product; valid while mul_done is qualified
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer favours requester 0, watchdog 0, done_seen_low 0.
//    Async assert; mid-job reset abandons the job with no rsp.
//  State machine: IDLE -> ISSUE -> WAIT -> RESP -> IDLE (all registered).
//  IDLE
//    - If req0|req1: pick owner, latch x/y into mul_x/mul_y, go ISSUE.
//    - Only one requesting: that one wins.
//    - Both requesting: the one NOT granted last wins, and the pointer flips to the winner.
//    - After reset, a simultaneous request grants 0.
//  ISSUE (1 cycle)
//    - mul_start=1 and gntN=1 (owner only), busy=1.
//    - Clear watchdog and done_seen_low. Go WAIT.
//  WAIT
//    - mul_done is qualified only after it has been observed low in at least one WAIT cycle.
//      This blocks a stale done level from the previous job.
//    - Qualified mul_done=1: capture mul_product into resultN of owner, go RESP.
//    - Otherwise the watchdog increments.
//    - Watchdog reaching TIMEOUT: go RESP with abort flag set; resultN is left unchanged.
//    - A qualified done in the same cycle as timeout wins: normal completion.
//  RESP (1 cycle)
//    - rspN=1 for owner; errN=1 additionally if aborted. Go IDLE.
//  Latency
//    - Request sampled in cycle t gives gnt/mul_start in t+1.
//    - Qualified done in cycle d gives rsp in d+1, and the next grant no earlier than d+2.
//  req handling
//    - req held high through a job counts as a new request when IDLE is re-entered.
//    - A requester wanting one job drops req after its gnt.
//    - req changes outside IDLE are ignored. Operand changes after gnt do not affect the job.
//  Outputs
//    - gnt/rsp/err/mul_start are mutually exclusive per cycle and are never asserted for both requesters.
//    - Products are taken unmodified (2*WIDTH bits; no truncation or sign handling here).
// TESTING
//  1. Reset, then req0=1 with x0=8'd5, y0=8'd7 for 1 cycle; multiplier gives done after 6 cycles.
//     -> gnt0 and mul_start at t+1, mul_x=5, mul_y=7, rsp0 pulse, result0=16'd35, err0=0.
//  2. req0 and req1 both held 1 from reset, operands (3,4) and (6,6).
//     -> grants alternate 0,1,0,1; result0=12, result1=36; never two gnts in one cycle.
//  3. mul_done tied high before the job, drops 1 cycle after start, rises 5 cycles later.
//     -> no early completion; rsp at rise+1 with the correct product.
//  4. Multiplier stalls (done stays 0), TIMEOUT=64.
//     -> after 64 WAIT cycles: rspN=1 and errN=1 together, resultN unchanged, busy low next cycle.
//  5. Assert rst during WAIT of a req1 job.
//     -> all outputs 0 immediately; no rsp1. A subsequent simultaneous request grants requester 0 first.
//  6. Change x0/y0 one cycle after gnt0.
//     -> mul_x/mul_y and result0 reflect the originally sampled operands.

Source files
------------

// File: rtl/mult_share_arbiter_if.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter_if
// Purpose : bundles the two requester ports and the shared-multiplier
//           handshake of mult_share_arbiter into one interface.
// Signals : req0/req1, x0/y0/x1/y1          requester requests and operands
//           gnt0/gnt1, rsp0/rsp1, err0/err1  per-requester pulses
//           result0/result1                  held per-requester products
//           busy                             arbiter not idle
//           mul_start, mul_x, mul_y          start pulse and latched operands
//           mul_done, mul_product            multiplier completion and product
// Modports: slave  - the arbiter
//           master - the environment (requesters plus multiplier)
// ---------------------------------------------------------------------------
interface mult_share_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 req0;
    logic                 req1;
    logic [WIDTH-1:0]     x0;
    logic [WIDTH-1:0]     y0;
    logic [WIDTH-1:0]     x1;
    logic [WIDTH-1:0]     y1;
    logic                 gnt0;
    logic                 gnt1;
    logic                 rsp0;
    logic                 rsp1;
    logic                 err0;
    logic                 err1;
    logic [2*WIDTH-1:0]   result0;
    logic [2*WIDTH-1:0]   result1;
    logic                 busy;
    logic                 mul_start;
    logic [WIDTH-1:0]     mul_x;
    logic [WIDTH-1:0]     mul_y;
    logic                 mul_done;
    logic [2*WIDTH-1:0]   mul_product;

    modport slave (
        input  req0, req1, x0, y0, x1, y1, mul_done, mul_product,
        output gnt0, gnt1, rsp0, rsp1, err0, err1, result0, result1,
               busy, mul_start, mul_x, mul_y
    );

    modport master (
        output req0, req1, x0, y0, x1, y1, mul_done, mul_product,
        input  gnt0, gnt1, rsp0, rsp1, err0, err1, result0, result1,
               busy, mul_start, mul_x, mul_y
    );
endinterface

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
// Purpose : shares one start/done sequential multiplier between two
//           requesters with round-robin arbitration, stale-done filtering
//           and a watchdog that aborts a job whose done never arrives.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous active-high reset
//           bus  - mult_share_arbiter_if.slave (requesters + multiplier)
// All outputs are registered.
// ---------------------------------------------------------------------------
module mult_share_arbiter #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    mult_share_arbiter_if.slave  bus
);
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned WD_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } arbState_t;

    arbState_t          state, stateNext;
    // Owner of the current job; also the round-robin "granted last" pointer.
    logic               lastOwner, lastOwnerNext;
    logic               doneSeenLow, doneSeenLowNext;
    logic [WD_W-1:0]    watchdog, watchdogNext;
    logic [WIDTH-1:0]   mulX, mulXNext, mulY, mulYNext;
    logic [PROD_W-1:0]  result0Q, result0Next, result1Q, result1Next;
    logic               gnt0Q, gnt0Next, gnt1Q, gnt1Next;
    logic               rsp0Q, rsp0Next, rsp1Q, rsp1Next;
    logic               err0Q, err0Next, err1Q, err1Next;
    logic               busyQ, busyNext, startQ, startNext;
    logic               pick;
    logic               doneQual;

    // A done level only counts once it has been seen low during this job.
    assign doneQual = bus.mul_done & doneSeenLow;

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            lastOwner   <= 1'b1;
            doneSeenLow <= 1'b0;
            watchdog    <= '0;
            mulX        <= '0;
            mulY        <= '0;
            result0Q    <= '0;
            result1Q    <= '0;
            gnt0Q       <= 1'b0;
            gnt1Q       <= 1'b0;
            rsp0Q       <= 1'b0;
            rsp1Q       <= 1'b0;
            err0Q       <= 1'b0;
            err1Q       <= 1'b0;
            busyQ       <= 1'b0;
            startQ      <= 1'b0;
        end else begin
            state       <= stateNext;
            lastOwner   <= lastOwnerNext;
            doneSeenLow <= doneSeenLowNext;
            watchdog    <= watchdogNext;
            mulX        <= mulXNext;
            mulY        <= mulYNext;
            result0Q    <= result0Next;
            result1Q    <= result1Next;
            gnt0Q       <= gnt0Next;
            gnt1Q       <= gnt1Next;
            rsp0Q       <= rsp0Next;
            rsp1Q       <= rsp1Next;
            err0Q       <= err0Next;
            err1Q       <= err1Next;
            busyQ       <= busyNext;
            startQ      <= startNext;
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        stateNext       = state;
        lastOwnerNext   = lastOwner;
        doneSeenLowNext = doneSeenLow;
        watchdogNext    = watchdog;
        mulXNext        = mulX;
        mulYNext        = mulY;
        result0Next     = result0Q;
        result1Next     = result1Q;
        gnt0Next        = 1'b0;
        gnt1Next        = 1'b0;
        rsp0Next        = 1'b0;
        rsp1Next        = 1'b0;
        err0Next        = 1'b0;
        err1Next        = 1'b0;
        startNext       = 1'b0;
        pick            = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.req0 | bus.req1) begin
                    // Contention goes to whoever was not granted last.
                    if (bus.req0 & bus.req1) pick = ~lastOwner;
                    else                     pick = bus.req1;
                    lastOwnerNext = pick;
                    mulXNext      = pick ? bus.x1 : bus.x0;
                    mulYNext      = pick ? bus.y1 : bus.y0;
                    gnt0Next      = ~pick;
                    gnt1Next      = pick;
                    startNext     = 1'b1;
                    stateNext     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                watchdogNext    = '0;
                doneSeenLowNext = 1'b0;
                stateNext       = ST_WAIT;
            end
            ST_WAIT: begin
                if (doneQual) begin
                    // Completion wins over a coincident timeout.
                    if (lastOwner) begin
                        result1Next = bus.mul_product;
                        rsp1Next    = 1'b1;
                    end else begin
                        result0Next = bus.mul_product;
                        rsp0Next    = 1'b1;
                    end
                    stateNext = ST_RESP;
                end else begin
                    if (!bus.mul_done) doneSeenLowNext = 1'b1;
                    watchdogNext = watchdog + WD_W'(1);
                    if (watchdogNext == WD_W'(TIMEOUT)) begin
                        rsp0Next  = ~lastOwner;
                        rsp1Next  = lastOwner;
                        err0Next  = ~lastOwner;
                        err1Next  = lastOwner;
                        stateNext = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                stateNext = ST_IDLE;
            end
            default: begin
                stateNext = ST_IDLE;
            end
        endcase

        busyNext = (stateNext != ST_IDLE);
    end

    assign bus.gnt0      = gnt0Q;
    assign bus.gnt1      = gnt1Q;
    assign bus.rsp0      = rsp0Q;
    assign bus.rsp1      = rsp1Q;
    assign bus.err0      = err0Q;
    assign bus.err1      = err1Q;
    assign bus.result0   = result0Q;
    assign bus.result1   = result1Q;
    assign bus.busy      = busyQ;
    assign bus.mul_start = startQ;
    assign bus.mul_x     = mulX;
    assign bus.mul_y     = mulY;
endmodule
